fft_sdf_r2_stage: RTL and testbench
===================================

# fft_sdf_r2_stage

Parametrised radix-2 decimation-in-frequency (DIF) butterfly stage in single-path delay-feedback (SDF) form. It accepts one complex sample per cycle and stores the first half of each 2D-sample block in an internal delay memory. It emits butterfly sums during the second half and drains twiddle-rotated differences automatically, with or without further input. Stages are chained with STAGE = 0 .. log2(N)-1 to build a streaming N-point FFT; twiddles come from an external combinational ROM.

## Interface
- N, 64: FFT size; power of two, ≥ 4.
- STAGE, 0: stage index; delay D = N >> (STAGE+1), must be ≥ 1.
- DW, 16: signed data width, real and imag.
- TW, 14: signed twiddle width; Q(TW-2), so 2^(TW-2) = 1.0.
- SCALE, 1: 1 = butterfly result arithmetic-shifted right by 1 (truncate); 0 = no scaling, saturate.
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous abandon-frame clear.
- in_valid_i  in  1  input sample valid; always accepted (no ready).
- in_real_i / in_imag_i  in  DW  input sample.
- tw_addr_o  out  log2(N)-1  twiddle ROM index, combinational.
- tw_real_i / tw_imag_i  in  TW  W_N^tw_addr_o, same cycle.
- out_valid_o  out  1  output sample valid.
- out_sum_o  out  1  1 = sum output, 0 = rotated difference.
- out_real_o / out_imag_o  out  DW  output sample.
- ovf_o  out  1  saturation occurred on this output sample (qualified by out_valid_o).

## Operation
- Block counter k (log2(2D) bits) counts accepted inputs. Phase A: k < D. Phase B: k ≥ D. k wraps 2D-1 -> 0.
- Delay memory mem[0..D-1], combinational read, write at clock edge. Read-before-write holds within a cycle.
- Phase A, input accepted at j = k: mem[j] <= x.
- Phase B, input accepted at j = k-D:
  - sum = mem[j] + x, output with out_sum_o=1.
  - mem[j] <= mem[j] - x.
  - Both are computed at DW+1 bits, then shifted (SCALE=1) or saturated (SCALE=0).
- Drain: when the last phase-B input of a block is accepted, pending <= 1 and rd <= 0.
  - While pending, every cycle (independent of in_valid_i) read mem[rd], multiply by twiddle and output with out_sum_o=0.
  - rd increments; pending clears after rd = D-1.
- tw_addr_o = rd << STAGE while pending, else 0.
- No conflict with new input: the drain runs only during phase A and rd advances every cycle, so rd ≥ k always. Write to mem[k] never precedes the read of mem[k].
- Phase-A inputs produce no output. Phase-B sums and drain outputs never coincide.
- Complex multiply: p = d·w at DW+TW bits; add 2^(TW-3); arithmetic shift right TW-2; saturate to DW.
- Saturation of either component in the butterfly or the multiply sets ovf_o for that output.
- clr_i: k, rd, pending <= 0. mem contents are don't-care. out_valid_o <= 0 next cycle. An input presented with clr_i is discarded.
- States, implicit in (k, pending): FILL (A, idle), FILL+DRAIN (A, pending), BFLY (B). pending is never set in BFLY.

## Timing
- Reset values: out_valid_o=0, out_sum_o=0, out_real_o=0, out_imag_o=0, ovf_o=0, tw_addr_o=0. k=0, rd=0, pending=0.
- Sum latency: input accepted at cycle t -> output at t+1.
- Drain: last phase-B input at t -> diff[0] at t+2, diff[D-1] at t+D+1, on consecutive cycles.
- Continuous input: one output per cycle from the first phase-B sum onward, no bubbles.
- Input gaps: in phase A, the drain continues and no outputs are missed. In phase B, sum outputs have gaps matching the input gaps.
- rstn_i asserted mid-frame: all state and outputs clear asynchronously. The next accepted input is k=0.

## Test plan
Common setup: N=8, STAGE=0, D=4, TW=14. W8^0..3 = (4096,0), (2896,-2896), (0,-4096), (-2896,-2896).
- Impulse, SCALE=0: x = 1000,0,...,0 on 8 consecutive cycles -> sums 1000,0,0,0 at cycles 5-8; diffs 1000,0,0,0 (imag 0) at cycles 9-12; out_sum_o 1 then 0.
- DC, SCALE=1: x = 1000 ×8 -> sums 1000 ×4; diffs 0 ×4; ovf_o=0.
- Twiddle rounding, SCALE=0: x[1]=2000, others 0 -> sum[1]=2000; diff[1]=(1414,-1414); all other outputs 0.
- Saturation, SCALE=0: x[0]=x[4]=30000 -> sum[0]=32767 with ovf_o=1; diff[0]=0 with ovf_o=0.
- Gaps and drain: 8 inputs with 3 idle cycles inserted inside phase B, then in_valid_i low -> 4 sums with gaps, then 4 diffs on consecutive cycles.
- Back-to-back frames: 16 inputs, no gaps -> 16 outputs with no gaps.
- Mid-frame clear: clr_i at k=6, then a fresh frame -> the fresh frame's outputs only.
- Mid-frame reset: rstn_i low at k=6, then a fresh frame -> the fresh frame's outputs only.

Source files
------------

// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 DIF butterfly stage, single-path delay-feedback form.
// One complex sample per cycle; sums stream out in phase B, rotated differences drain in phase A.
module fft_sdf_r2_stage #(
  parameter int unsigned N     = 64,
  parameter int unsigned STAGE = 0,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 14,
  parameter int unsigned SCALE = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 in_valid_i,
  input  logic [DW-1:0]        in_real_i,
  input  logic [DW-1:0]        in_imag_i,
  output logic [$clog2(N)-2:0] tw_addr_o,
  input  logic [TW-1:0]        tw_real_i,
  input  logic [TW-1:0]        tw_imag_i,
  output logic                 out_valid_o,
  output logic                 out_sum_o,
  output logic [DW-1:0]        out_real_o,
  output logic [DW-1:0]        out_imag_o,
  output logic                 ovf_o
);

  localparam int unsigned D  = N >> (STAGE + 1);
  localparam int unsigned KW = $clog2(2 * D);
  localparam int unsigned RW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned AW = $clog2(N) - 1;
  localparam int unsigned PW = DW + TW + 1;
  localparam logic signed [PW-1:0] Rnd = PW'(1) << (TW - 3);

  logic [KW-1:0] k_q;
  logic [RW-1:0] rd_q;
  logic          pending_q;
  logic [DW-1:0] mem_re_q  [D];
  logic [DW-1:0] mem_im_q  [D];
  logic          mem_ovf_q [D];

  logic          in_acc, phase_b, last_b, rd_last;
  logic [RW-1:0] wr_idx;

  logic signed [DW:0]   bf_sum_re, bf_sum_im, bf_dif_re, bf_dif_im;
  logic [DW:0]          sum_re_f, sum_im_f, dif_re_f, dif_im_f;
  logic signed [PW-1:0] d_re, d_im, w_re, w_im, p_re, p_im;
  logic [DW:0]          mul_re_f, mul_im_f;

  // Returned as {ovf, value}.
  function automatic logic [DW:0] bfly_fix(input logic [DW:0] v);
    if (SCALE != 0) return {1'b0, v[DW:1]};
    if (v[DW] != v[DW-1]) return {1'b1, v[DW], {(DW-1){~v[DW]}}};
    return {1'b0, v[DW-1:0]};
  endfunction

  function automatic logic [DW:0] mul_fix(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + Rnd) >>> (TW - 2);
    if ((&r[PW-1:DW-1]) || !(|r[PW-1:DW-1])) return {1'b0, r[DW-1:0]};
    return {1'b1, r[PW-1], {(DW-1){~r[PW-1]}}};
  endfunction

  assign in_acc  = in_valid_i & ~clr_i;
  assign phase_b = k_q[KW-1];
  assign last_b  = in_acc & (&k_q);
  assign rd_last = (rd_q == RW'(D - 1));
  assign wr_idx  = RW'(k_q & KW'(D - 1));

  assign bf_sum_re = $signed({mem_re_q[wr_idx][DW-1], mem_re_q[wr_idx]})
                   + $signed({in_real_i[DW-1], in_real_i});
  assign bf_sum_im = $signed({mem_im_q[wr_idx][DW-1], mem_im_q[wr_idx]})
                   + $signed({in_imag_i[DW-1], in_imag_i});
  assign bf_dif_re = $signed({mem_re_q[wr_idx][DW-1], mem_re_q[wr_idx]})
                   - $signed({in_real_i[DW-1], in_real_i});
  assign bf_dif_im = $signed({mem_im_q[wr_idx][DW-1], mem_im_q[wr_idx]})
                   - $signed({in_imag_i[DW-1], in_imag_i});

  assign sum_re_f = bfly_fix(bf_sum_re);
  assign sum_im_f = bfly_fix(bf_sum_im);
  assign dif_re_f = bfly_fix(bf_dif_re);
  assign dif_im_f = bfly_fix(bf_dif_im);

  assign d_re = PW'($signed(mem_re_q[rd_q]));
  assign d_im = PW'($signed(mem_im_q[rd_q]));
  assign w_re = PW'($signed(tw_real_i));
  assign w_im = PW'($signed(tw_imag_i));
  assign p_re = d_re * w_re - d_im * w_im;
  assign p_im = d_re * w_im + d_im * w_re;

  assign mul_re_f = mul_fix(p_re);
  assign mul_im_f = mul_fix(p_im);

  assign tw_addr_o = pending_q ? (AW'(rd_q) << STAGE) : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      k_q         <= '0;
      rd_q        <= '0;
      pending_q   <= 1'b0;
      out_valid_o <= 1'b0;
      out_sum_o   <= 1'b0;
      out_real_o  <= '0;
      out_imag_o  <= '0;
      ovf_o       <= 1'b0;
    end else if (clr_i) begin
      k_q         <= '0;
      rd_q        <= '0;
      pending_q   <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (in_acc) k_q <= k_q + 1'b1;
      if (pending_q) begin
        rd_q <= rd_q + 1'b1;
        if (rd_last) pending_q <= 1'b0;
      end
      // Drain only ever runs in phase A, so it never overlaps the last phase-B input.
      if (last_b) begin
        pending_q <= 1'b1;
        rd_q      <= '0;
      end
      out_valid_o <= 1'b0;
      if (in_acc && phase_b) begin
        out_valid_o <= 1'b1;
        out_sum_o   <= 1'b1;
        out_real_o  <= sum_re_f[DW-1:0];
        out_imag_o  <= sum_im_f[DW-1:0];
        ovf_o       <= sum_re_f[DW] | sum_im_f[DW];
      end else if (pending_q) begin
        out_valid_o <= 1'b1;
        out_sum_o   <= 1'b0;
        out_real_o  <= mul_re_f[DW-1:0];
        out_imag_o  <= mul_im_f[DW-1:0];
        ovf_o       <= mem_ovf_q[rd_q] | mul_re_f[DW] | mul_im_f[DW];
      end
    end
  end

  // Delay memory is unreset: every entry is rewritten in phase A before it is read.
  always_ff @(posedge clk_i) begin
    if (in_acc) begin
      if (phase_b) begin
        mem_re_q[wr_idx]  <= dif_re_f[DW-1:0];
        mem_im_q[wr_idx]  <= dif_im_f[DW-1:0];
        mem_ovf_q[wr_idx] <= dif_re_f[DW] | dif_im_f[DW];
      end else begin
        mem_re_q[wr_idx]  <= in_real_i;
        mem_im_q[wr_idx]  <= in_imag_i;
        mem_ovf_q[wr_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
// Directed bench for fft_sdf_r2_stage at N=8, STAGE=0; one DUT per SCALE setting.
module tb_fft_sdf_r2_stage;

  logic        clk = 1'b0;
  logic        rstn, clr, in_valid;
  logic [15:0] in_re, in_im;

  logic [1:0]  tw_addr0, tw_addr1;
  logic [13:0] twr0, twi0, twr1, twi1;
  logic        v0, s0, o0, v1, s1, o1;
  logic [15:0] re0, im0, re1, im1;

  typedef struct {
    logic vld;
    logic clr;
    int   re;
    int   im;
    logic ev;
    logic es;
    int   er;
    int   ei;
    logic eo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [27:0] rom(input logic [1:0] a);
    logic [13:0] r, i;
    case (a)
      2'd0:    begin r = 14'(4096);  i = 14'(0);     end
      2'd1:    begin r = 14'(2896);  i = 14'(-2896); end
      2'd2:    begin r = 14'(0);     i = 14'(-4096); end
      default: begin r = 14'(-2896); i = 14'(-2896); end
    endcase
    return {r, i};
  endfunction

  assign {twr0, twi0} = rom(tw_addr0);
  assign {twr1, twi1} = rom(tw_addr1);

  fft_sdf_r2_stage #(.N(8), .STAGE(0), .DW(16), .TW(14), .SCALE(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .in_valid_i(in_valid),
    .in_real_i(in_re), .in_imag_i(in_im), .tw_addr_o(tw_addr0),
    .tw_real_i(twr0), .tw_imag_i(twi0), .out_valid_o(v0), .out_sum_o(s0),
    .out_real_o(re0), .out_imag_o(im0), .ovf_o(o0)
  );

  fft_sdf_r2_stage #(.N(8), .STAGE(0), .DW(16), .TW(14), .SCALE(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .in_valid_i(in_valid),
    .in_real_i(in_re), .in_imag_i(in_im), .tw_addr_o(tw_addr1),
    .tw_real_i(twr1), .tw_imag_i(twi1), .out_valid_o(v1), .out_sum_o(s1),
    .out_real_o(re1), .out_imag_o(im1), .ovf_o(o1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want $finish");
    $fatal(1);
  end

  function automatic void add(bit v, bit c, int re, int im, bit ev, bit es, int er, int ei,
                              bit eo);
    vec_t r;
    r.vld = v; r.clr = c; r.re = re; r.im = im;
    r.ev = ev; r.es = es; r.er = er; r.ei = ei; r.eo = eo;
    vecs.push_back(r);
  endfunction

  task automatic check_row(input bit sel, input string name, input int row, input vec_t x);
    logic av, as, ao;
    int   ar, ai;
    bit   ok;
    av = sel ? v1 : v0;
    as = sel ? s1 : s0;
    ao = sel ? o1 : o0;
    ar = sel ? int'($signed(re1)) : int'($signed(re0));
    ai = sel ? int'($signed(im1)) : int'($signed(im0));
    checks++;
    if (!x.ev) ok = (av == 1'b0);
    else ok = av && (as == x.es) && (ar == x.er) && (ai == x.ei) && (ao == x.eo);
    if (!ok) begin
      errors++;
      $display("FAIL %s row %0d: got v=%0d s=%0d re=%0d im=%0d ovf=%0d, want v=%0d s=%0d re=%0d im=%0d ovf=%0d",
               name, row, av, as, ar, ai, ao, x.ev, x.es, x.er, x.ei, x.eo);
    end
  endtask

  task automatic run(input bit sel, input string name);
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].vld;
      clr      = vecs[i].clr;
      in_re    = 16'(vecs[i].re);
      in_im    = 16'(vecs[i].im);
      @(posedge clk);
      #1;
      check_row(sel, name, i, vecs[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    vecs.delete();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({v0, s0, o0, re0, im0, tw_addr0, v1, s1, o1, re1, im1, tw_addr1} != '0) begin
      errors++;
      $display("FAIL %s: got v=%0d/%0d s=%0d/%0d re=%0d/%0d im=%0d/%0d ovf=%0d/%0d tw=%0d/%0d, want all 0",
               name, v0, v1, s0, s1, re0, re1, im0, im1, o0, o1, tw_addr0, tw_addr1);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Old frame up to k=6, then a fresh impulse frame of amplitude 500.
  task automatic old_frame();
    for (int i = 0; i < 4; i++) add(1, 0, 300, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 0, 300, 0, 1, 1, 600, 0, 0);
  endtask

  task automatic fresh_frame();
    add(1, 0, 500, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1, (i == 0) ? 500 : 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, (i == 0) ? 500 : 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int dr[4], di[4];
    rstn = 1'b1; clr = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
    #2 rstn = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Impulse, SCALE=0
    add(1, 0, 1000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1, (i == 0) ? 1000 : 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, (i == 0) ? 1000 : 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(0, "impulse");

    // DC then an odd-valued frame, SCALE=1 (truncating shift)
    reset_dut();
    for (int i = 0; i < 4; i++) add(1, 0, 1000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1000, 0, 1, 1, 1000, 0, 0);
    add(1, 0, 3, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, -6, 0, 1, 1, -2, 0, 0);
    for (int i = 1; i < 4; i++) add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, (i == 0) ? 4 : 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(1, "dc_scale");

    // Twiddle rounding, SCALE=0
    reset_dut();
    for (int i = 0; i < 4; i++) add(1, 0, (i == 1) ? 2000 : 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1, (i == 1) ? 2000 : 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 1, 0, (i == 1) ? 1414 : 0, (i == 1) ? -1414 : 0, 0);
    run(0, "twiddle");

    // Saturation, SCALE=0, positive real and negative imag
    reset_dut();
    add(1, 0, 30000, -30000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 30000, -30000, 1, 1, 32767, -32768, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    run(0, "saturate");

    // Gaps inside phase B, then drain with no input
    reset_dut();
    for (int i = 0; i < 4; i++) add(1, 0, 100 * (i + 1), 0, 0, 0, 0, 0, 0);
    add(1, 0, 10, 0, 1, 1, 110, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 20, 0, 1, 1, 220, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 30, 0, 1, 1, 330, 0, 0);
    add(1, 0, 40, 0, 1, 1, 440, 0, 0);
    dr = '{90, 127, 0, -255};
    di = '{0, -127, -270, -255};
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, dr[i], di[i], 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(0, "gaps");

    // Back-to-back frames: drain of frame 1 overlaps phase A of frame 2
    reset_dut();
    for (int i = 0; i < 4; i++) add(1, 0, 0, 100 * (i + 1), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1, 0, 100 * (i + 1), 0);
    dr = '{0, 141, 300, 283};
    di = '{100, 141, 0, -283};
    for (int i = 0; i < 4; i++) add(1, 0, 50, 0, 1, 0, dr[i], di[i], 0);
    for (int i = 0; i < 4; i++) add(1, 0, 10, 0, 1, 1, 60, 0, 0);
    dr = '{40, 28, 0, -28};
    di = '{0, -28, -40, -28};
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, dr[i], di[i], 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(0, "back2back");

    // Mid-frame clear at k=6; the sample presented with clr is dropped
    reset_dut();
    old_frame();
    add(1, 1, 999, 0, 0, 0, 0, 0, 0);
    fresh_frame();
    run(0, "clear");

    // Mid-frame asynchronous reset at k=6
    reset_dut();
    old_frame();
    run(0, "reset_pre");
    in_valid = 1'b1;
    in_re    = 16'(777);
    #2 rstn = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rstn     = 1'b1;
    in_valid = 1'b0;
    fresh_frame();
    run(0, "reset_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
